// File: rtl/conv_ilv_commutator.sv
// conv_ilv_commutator: commutator and sync controller for a byte-wide
// convolutional interleaver (I branches, branch k delays by k*UNIT bytes).
// Hunts the packet sync byte so packet byte 0 always enters branch 0, steps
// the branch per accepted byte, drives one-hot shift enables for the external
// delay lines and registers the selected branch output.
// Optional statistics counters are built when CONV_ILV_STATS_EN is defined.
module conv_ilv_commutator #(
    parameter int unsigned       BRANCHES = 12,
    parameter int unsigned       UNIT     = 17,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       PKT_LEN  = 204,
    parameter logic [DATA_W-1:0] SYNC     = 8'h47,
    parameter logic [DATA_W-1:0] SYNC_INV = 8'hB8,
    parameter int unsigned       MISS_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic [BRANCHES-1:0]           br_en,
    output logic [DATA_W-1:0]             br_wdata,
    input  logic [BRANCHES*DATA_W-1:0]    br_rdata,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          locked,
    output logic                          primed,
    output logic [$clog2(BRANCHES)-1:0]   branch_idx
`ifdef CONV_ILV_STATS_EN
    ,
    output logic [15:0]                   sync_loss_cnt,
    output logic [31:0]                   pkt_cnt
`endif
);

    localparam int unsigned BR_W   = $clog2(BRANCHES);
    localparam int unsigned POS_W  = $clog2(PKT_LEN);
    localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);
    localparam int unsigned FILL   = UNIT * BRANCHES * (BRANCHES - 1);
    localparam int unsigned FILL_W = $clog2(FILL + 1);

    typedef enum logic {
        ST_SEARCH,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    logic [BR_W-1:0]     r_branch;
    logic [POS_W-1:0]    r_pkt_pos;
    logic [MISS_W-1:0]   r_miss;
    logic [FILL_W-1:0]   r_fill;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_primed;

    logic                w_is_sync;
    logic                w_pos0;
    logic [MISS_W-1:0]   w_miss_inc;
    logic                w_loss;
    logic                w_accept;
    logic [BR_W-1:0]     w_branch_nxt;
    logic [POS_W-1:0]    w_pos_nxt;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic [BRANCHES-1:0] w_br_en;
    logic [DATA_W-1:0]   w_rd_sel;

    // Accept/drop decision, next-index arithmetic and shift-enable decode
    always_comb begin
        w_is_sync    = (in_data == SYNC) || (in_data == SYNC_INV);
        w_pos0       = (r_pkt_pos == '0);
        w_miss_inc   = r_miss + 1'b1;
        // Third consecutive bad sync: this byte is discarded and lock drops
        w_loss       = (r_state == ST_LOCKED) && in_valid && w_pos0 && !w_is_sync &&
                       (w_miss_inc == MISS_W'(MISS_MAX));
        w_accept     = in_valid && ((r_state == ST_SEARCH) ? w_is_sync : !w_loss);
        w_branch_nxt = (r_branch == BR_W'(BRANCHES - 1)) ? '0 : r_branch + 1'b1;
        w_pos_nxt    = (r_pkt_pos == POS_W'(PKT_LEN - 1)) ? '0 : r_pkt_pos + 1'b1;
        w_fill_nxt   = (r_fill == FILL_W'(FILL)) ? r_fill : r_fill + 1'b1;
        w_rd_sel     = br_rdata[r_branch*DATA_W +: DATA_W];
        w_br_en      = '0;
        // Branch 0 has no delay line, so it never gets a shift enable
        if ((r_state == ST_LOCKED) && in_valid && !w_loss && (r_branch != '0)) begin
            w_br_en[r_branch] = 1'b1;
        end
    end

    // Sync FSM, commutator indices, fill tracking and registered output byte
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_SEARCH;
            r_branch    <= '0;
            r_pkt_pos   <= '0;
            r_miss      <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_primed    <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= (r_branch == '0) ? in_data : w_rd_sel;
                r_branch   <= w_branch_nxt;
                r_pkt_pos  <= w_pos_nxt;
                r_fill     <= w_fill_nxt;
                if (w_fill_nxt == FILL_W'(FILL)) begin
                    r_primed <= 1'b1;
                end
            end
            case (r_state)
                ST_SEARCH: begin
                    if (w_accept) begin
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (in_valid && w_pos0) begin
                        if (w_is_sync) begin
                            r_miss <= '0;
                        end else if (w_loss) begin
                            r_state   <= ST_SEARCH;
                            r_branch  <= '0;
                            r_pkt_pos <= '0;
                            r_miss    <= '0;
                            r_fill    <= '0;
                            r_primed  <= 1'b0;
                        end else begin
                            r_miss <= w_miss_inc;
                        end
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

`ifdef CONV_ILV_STATS_EN
    logic [15:0] r_sync_loss_cnt;
    logic [31:0] r_pkt_cnt;

    // Lock-loss (saturating) and packet-start (wrapping) statistics
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync_loss_cnt <= '0;
            r_pkt_cnt       <= '0;
        end else begin
            if (w_loss && (r_sync_loss_cnt != '1)) begin
                r_sync_loss_cnt <= r_sync_loss_cnt + 1'b1;
            end
            if ((r_state == ST_LOCKED) && w_accept && w_pos0) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign sync_loss_cnt = r_sync_loss_cnt;
    assign pkt_cnt       = r_pkt_cnt;
`endif

    assign br_en      = w_br_en;
    assign br_wdata   = in_data;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign locked     = (r_state == ST_LOCKED);
    assign primed     = r_primed;
    assign branch_idx = r_branch;

endmodule

// File: tb/tb_conv_ilv_commutator.sv
// Testbench for conv_ilv_commutator: behavioural delay lines, directed byte
// stream, expected output bytes queued at issue and checked by a monitor.
module tb_conv_ilv_commutator;

    localparam int BR   = 12;
    localparam int UNIT = 17;
    localparam int DW   = 8;
    localparam int PKT  = 204;
    localparam int FILL = 2244;
    localparam int MAXL = UNIT * (BR - 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic [BR-1:0]    br_en;
    logic [DW-1:0]    br_wdata;
    logic [BR*DW-1:0] br_rdata;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             locked;
    logic             primed;
    logic [3:0]       branch_idx;
`ifdef CONV_ILV_STATS_EN
    logic [15:0]      sync_loss_cnt;
    logic [31:0]      pkt_cnt;
`endif

    always #5 clk = ~clk;

    conv_ilv_commutator #(
        .BRANCHES (BR),
        .UNIT     (UNIT),
        .DATA_W   (DW),
        .PKT_LEN  (PKT),
        .SYNC     (8'h47),
        .SYNC_INV (8'hB8),
        .MISS_MAX (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .br_en      (br_en),
        .br_wdata   (br_wdata),
        .br_rdata   (br_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .locked     (locked),
        .primed     (primed),
        .branch_idx (branch_idx)
`ifdef CONV_ILV_STATS_EN
        ,
        .sync_loss_cnt (sync_loss_cnt),
        .pkt_cnt       (pkt_cnt)
`endif
    );

    // Behavioural delay lines: branch k is k*UNIT byte registers
    logic [DW-1:0] dl [BR][MAXL];

    always_ff @(posedge clk) begin
        for (int k = 1; k < BR; k++) begin
            if (br_en[k]) begin
                for (int j = 0; j < MAXL; j++) begin
                    if (j < k * UNIT) begin
                        if (j == 0) dl[k][j] <= br_wdata;
                        else        dl[k][j] <= dl[k][j-1];
                    end
                end
            end
        end
    end

    always_comb begin
        br_rdata = '0;
        for (int k = 1; k < BR; k++) begin
            br_rdata[k*DW +: DW] = dl[k][k*UNIT-1];
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        bit            care;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] wlog [BR][1024];
    int            wcnt [BR];
    int            checks = 0;
    int            errors = 0;
    int            pos    = 0;
    int            nproc  = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one valid byte; proc says whether it should be processed, br is the
    // branch it must land on. Expected output byte comes from the write log.
    task automatic send(input logic [DW-1:0] d, input bit proc, input int br);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk("br_en", 32'(br_en), (proc && br != 0) ? (32'd1 << br) : 32'd0);
        chk("branch_idx", 32'(branch_idx), 32'(br));
        if (proc) begin
            if (br == 0) begin
                e.d = d;
                e.care = 1'b1;
            end else begin
                if (wcnt[br] >= br * UNIT) begin
                    e.d = wlog[br][wcnt[br] - br*UNIT];
                    e.care = 1'b1;
                end else begin
                    e.d = '0;
                    e.care = 1'b0;
                end
                wlog[br][wcnt[br]] = d;
                wcnt[br]++;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic stream(input logic [DW-1:0] d);
        send(d, 1'b1, pos % BR);
        pos = (pos + 1) % PKT;
        nproc++;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hA5;
        #1;
        chk("br_en_idle", 32'(br_en), 32'd0);
    endtask

    // Monitor: every accepted byte must appear exactly one cycle later
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL out_valid_missing actual=%0b expected=1 t=%0t", out_valid, $time);
                end else if (e.care) begin
                    checks++;
                    if (out_data !== e.d) begin
                        errors++;
                        $display("FAIL out_data actual=%0h expected=%0h t=%0t", out_data, e.d, $time);
                    end
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL out_valid_spurious actual=%0b expected=0 t=%0t", out_valid, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        for (int k = 0; k < BR; k++) wcnt[k] = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        @(negedge clk);
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_primed", 32'(primed), 0);
        chk("rst_branch_idx", 32'(branch_idx), 0);
        chk("rst_br_en", 32'(br_en), 0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Sync hunt: non-sync bytes dropped, 0x47 locks on branch 0
        send(8'h00, 1'b0, 0);
        send(8'h12, 1'b0, 0);
        @(posedge clk); #1;
        chk("hunt_locked0", 32'(locked), 0);
        send(8'h47, 1'b1, 0);
        pos = 1;
        nproc = 1;
        @(posedge clk); #1;
        chk("hunt_locked1", 32'(locked), 1);
        chk("hunt_branch1", 32'(branch_idx), 1);

        // Commutation over two full branch cycles
        for (int i = 1; i <= 24; i++) stream(8'(i));

        // Gaps: branch only advances on valid cycles
        stream(8'h19);
        idle();
        idle();
        stream(8'h1A);
        idle();
        stream(8'h1B);

        // Fill to prime; primed must rise exactly on the FILL-th processed byte
        while (nproc < FILL) begin
            d = (pos == 0) ? 8'h47 : 8'(nproc * 5 + 1);
            stream(d);
            @(posedge clk); #1;
            chk("primed", 32'(primed), (nproc >= FILL) ? 32'd1 : 32'd0);
        end
        chk("prime_pos", 32'(pos), 0);

        // Two bad-sync packets still processed, third bad sync drops lock
        for (int p = 0; p < 2; p++) begin
            stream(8'h00);
            for (int i = 1; i < PKT; i++) stream(8'(i ^ (p * 8'h3C)));
        end
        chk("miss_still_locked", 32'(locked), 1);
        send(8'h00, 1'b0, 0);
        @(posedge clk); #1;
        chk("loss_locked", 32'(locked), 0);
        chk("loss_primed", 32'(primed), 0);
        chk("loss_branch", 32'(branch_idx), 0);
`ifdef CONV_ILV_STATS_EN
        chk("stats_loss", 32'(sync_loss_cnt), 1);
        chk("stats_pkt", pkt_cnt, 12);
`endif

        // Relock on the inverted sync byte
        send(8'hB8, 1'b1, 0);
        pos = 1;
        nproc = 1;
        @(posedge clk); #1;
        chk("relock_locked", 32'(locked), 1);
        for (int i = 1; i < 100; i++) stream(8'(i + 8'h80));
        chk("mid_pos", 32'(pos), 100);

        // Reset mid-packet at pkt_pos 100
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_out_data", 32'(out_data), 0);
        chk("mrst_locked", 32'(locked), 0);
        chk("mrst_primed", 32'(primed), 0);
        chk("mrst_branch", 32'(branch_idx), 0);
`ifdef CONV_ILV_STATS_EN
        chk("mrst_stats_loss", 32'(sync_loss_cnt), 0);
        chk("mrst_stats_pkt", pkt_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        send(8'h47, 1'b1, 0);
        pos = 1;
        nproc = 1;
        stream(8'h55);
        idle();
        idle();
        idle();
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
